// File: rtl/midi_msg_ctrl.sv
// MIDI receive controller: frames serial bytes sampled once per bit and
// decodes Note On/Off events with running status and real-time pass-through.
module midi_msg_ctrl #(
    parameter bit         CHAN_FILTER_EN = 1'b0,
    parameter logic [3:0] CHANNEL        = 4'h0
) (
    input  logic       clk,
    input  logic       r,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output logic       note_valid,
    output logic       note_on,
    output logic [3:0] note_chan,
    output logic [6:0] note_key,
    output logic [6:0] note_vel
);

    typedef enum logic [1:0] {IDLE, DATA, STOP, BREAK} state_t;

    state_t     state_reg;
    logic [2:0] bit_cnt_reg;
    logic [7:0] shreg_reg;
    logic       line_high_reg;

    logic [7:0] run_stat_reg;
    logic       idx_reg;
    logic [6:0] key_reg;

    logic is_note;
    logic chan_ok;

    // 0x8n / 0x9n are the only statuses whose data bytes we decode.
    assign is_note = (run_stat_reg[7:5] == 3'b100);
    assign chan_ok = !CHAN_FILTER_EN || (run_stat_reg[3:0] == CHANNEL);

    always_ff @(posedge clk) begin
        if (r) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= 3'd0;
            shreg_reg     <= 8'h00;
            line_high_reg <= 1'b0;
            byte_valid    <= 1'b0;
            rx_byte       <= 8'h00;
            frame_err     <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            // After reset the line may be mid-byte; require an idle-high
            // sample before trusting a falling edge as a start bit.
            if (rx) begin
                line_high_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (!rx && line_high_reg) begin
                        state_reg   <= DATA;
                        bit_cnt_reg <= 3'd0;
                    end
                end
                DATA: begin
                    shreg_reg[bit_cnt_reg] <= rx;
                    bit_cnt_reg            <= bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_reg <= STOP;
                    end
                end
                STOP: begin
                    if (rx) begin
                        rx_byte    <= shreg_reg;
                        byte_valid <= 1'b1;
                        state_reg  <= IDLE;
                    end else begin
                        frame_err <= 1'b1;
                        state_reg <= BREAK;
                    end
                end
                BREAK: begin
                    if (rx) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r) begin
            run_stat_reg <= 8'h00;
            idx_reg      <= 1'b0;
            key_reg      <= 7'h00;
            note_valid   <= 1'b0;
            note_on      <= 1'b0;
            note_chan    <= 4'h0;
            note_key     <= 7'h00;
            note_vel     <= 7'h00;
        end else begin
            note_valid <= 1'b0;
            if (byte_valid) begin
                if (rx_byte[7]) begin
                    if (rx_byte[7:4] == 4'hF) begin
                        // Real-time bytes (F8-FF) leave the message state untouched.
                        if (!rx_byte[3]) begin
                            run_stat_reg <= 8'h00;
                            idx_reg      <= 1'b0;
                        end
                    end else begin
                        run_stat_reg <= rx_byte;
                        idx_reg      <= 1'b0;
                    end
                end else if (is_note) begin
                    if (!idx_reg) begin
                        key_reg <= rx_byte[6:0];
                        idx_reg <= 1'b1;
                    end else begin
                        idx_reg <= 1'b0;
                        if (chan_ok) begin
                            note_valid <= 1'b1;
                            note_on    <= run_stat_reg[4] && (rx_byte[6:0] != 7'h00);
                            note_chan  <= run_stat_reg[3:0];
                            note_key   <= key_reg;
                            note_vel   <= rx_byte[6:0];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_msg_ctrl.sv
// Directed bench for midi_msg_ctrl: table of serial bytes with expected byte and
// note outputs, plus hand-written break and mid-byte reset sequences.
module tb_midi_msg_ctrl;

    logic clk = 1'b0;
    logic r   = 1'b1;
    logic rx  = 1'b1;

    logic       bv0, fe0, nv0, on0;
    logic [7:0] rxb0;
    logic [3:0] ch0;
    logic [6:0] key0, vel0;
    logic       bv1, fe1, nv1, on1;
    logic [7:0] rxb1;
    logic [3:0] ch1;
    logic [6:0] key1, vel1;

    always #5 clk = ~clk;

    midi_msg_ctrl dut0 (
        .clk(clk), .r(r), .rx(rx),
        .byte_valid(bv0), .rx_byte(rxb0), .frame_err(fe0),
        .note_valid(nv0), .note_on(on0), .note_chan(ch0),
        .note_key(key0), .note_vel(vel0)
    );

    midi_msg_ctrl #(.CHAN_FILTER_EN(1'b1), .CHANNEL(4'd2)) dut1 (
        .clk(clk), .r(r), .rx(rx),
        .byte_valid(bv1), .rx_byte(rxb1), .frame_err(fe1),
        .note_valid(nv1), .note_on(on1), .note_chan(ch1),
        .note_key(key1), .note_vel(vel1)
    );

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       sel;   // 0: unfiltered instance, 1: channel-2 filtered instance
        logic       nv;
        logic       on;
        logic [3:0] chan;
        logic [6:0] key;
        logic [6:0] vel;
    } vec_t;

    vec_t vecs [40];
    int   n_vec = 0;
    int   compared = 0;
    int   failed = 0;
    int   bv_cnt = 0;
    int   fe_cnt = 0;
    int   both_cnt = 0;
    bit   pend_valid = 1'b0;
    int   pend_idx = 0;

    always @(negedge clk) begin
        if (bv0) bv_cnt++;
        if (fe0) fe_cnt++;
        if (bv0 && fe0) both_cnt++;
    end

    task automatic add(input logic [7:0] d, input logic st, input logic sel,
                       input logic nv, input logic on, input logic [3:0] ch,
                       input logic [6:0] k, input logic [6:0] vl);
        vecs[n_vec].data = d;
        vecs[n_vec].stop = st;
        vecs[n_vec].sel  = sel;
        vecs[n_vec].nv   = nv;
        vecs[n_vec].on   = on;
        vecs[n_vec].chan = ch;
        vecs[n_vec].key  = k;
        vecs[n_vec].vel  = vl;
        n_vec++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic check_note(input int i);
        logic nv_s, on_s;
        logic [3:0] ch_s;
        logic [6:0] k_s, v_s;
        nv_s = vecs[i].sel ? nv1 : nv0;
        on_s = vecs[i].sel ? on1 : on0;
        ch_s = vecs[i].sel ? ch1 : ch0;
        k_s  = vecs[i].sel ? key1 : key0;
        v_s  = vecs[i].sel ? vel1 : vel0;
        chk($sformatf("v%0d note_valid", i), {31'd0, nv_s}, {31'd0, vecs[i].nv});
        if (vecs[i].nv) begin
            chk($sformatf("v%0d note_on", i), {31'd0, on_s}, {31'd0, vecs[i].on});
            chk($sformatf("v%0d note_chan", i), {28'd0, ch_s}, {28'd0, vecs[i].chan});
            chk($sformatf("v%0d note_key", i), {25'd0, k_s}, {25'd0, vecs[i].key});
            chk($sformatf("v%0d note_vel", i), {25'd0, v_s}, {25'd0, vecs[i].vel});
        end
    endtask

    // Drive one bit so the DUT samples it on the next edge, then look just after that edge.
    task automatic drive_bit(input logic b);
        rx = b;
        @(posedge clk);
        #1;
        if (pend_valid) begin
            pend_valid = 1'b0;
            check_note(pend_idx);
        end
    endtask

    task automatic send_vec(input int i);
        logic bv_s, fe_s, nv_s;
        logic [7:0] rxb_s;
        drive_bit(1'b0);
        for (int b = 0; b < 8; b++) drive_bit(vecs[i].data[b]);
        drive_bit(vecs[i].stop);
        bv_s  = vecs[i].sel ? bv1 : bv0;
        fe_s  = vecs[i].sel ? fe1 : fe0;
        nv_s  = vecs[i].sel ? nv1 : nv0;
        rxb_s = vecs[i].sel ? rxb1 : rxb0;
        chk($sformatf("v%0d byte_valid", i), {31'd0, bv_s}, {31'd0, vecs[i].stop});
        chk($sformatf("v%0d frame_err", i), {31'd0, fe_s}, {31'd0, !vecs[i].stop});
        chk($sformatf("v%0d early_note", i), {31'd0, nv_s}, 32'd0);
        if (vecs[i].stop) chk($sformatf("v%0d rx_byte", i), {24'd0, rxb_s}, {24'd0, vecs[i].data});
        pend_idx   = i;
        pend_valid = 1'b1;
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_vec(i);
        drive_bit(1'b1);
        drive_bit(1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int fe_base, bv_base;
        //   data  stop sel nv on ch    key    vel
        add(8'h90, 1, 0, 0, 0, 4'd0, 7'h00, 7'h00);  // 0
        add(8'h3C, 1, 0, 0, 0, 4'd0, 7'h00, 7'h00);
        add(8'h64, 1, 0, 1, 1, 4'd0, 7'h3C, 7'h64);
        add(8'h3C, 1, 0, 0, 0, 4'd0, 7'h00, 7'h00);  // running status
        add(8'h00, 1, 0, 1, 0, 4'd0, 7'h3C, 7'h00);
        add(8'h80, 1, 0, 0, 0, 4'd0, 7'h00, 7'h00);  // 5
        add(8'h40, 1, 0, 0, 0, 4'd0, 7'h00, 7'h00);
        add(8'h10, 1, 0, 1, 0, 4'd0, 7'h40, 7'h10);
        add(8'h95, 1, 0, 0, 0, 4'd0, 7'h00, 7'h00);
        add(8'h3C, 1, 0, 0, 0, 4'd0, 7'h00, 7'h00);
        add(8'hF8, 1, 0, 0, 0, 4'd0, 7'h00, 7'h00);  // 10 real-time inside message
        add(8'h64, 1, 0, 1, 1, 4'd5, 7'h3C, 7'h64);
        add(8'h90, 0, 0, 0, 0, 4'd0, 7'h00, 7'h00);  // 12 bad stop bit
        add(8'h90, 1, 0, 0, 0, 4'd0, 7'h00, 7'h00);
        add(8'h3C, 1, 0, 0, 0, 4'd0, 7'h00, 7'h00);
        add(8'h64, 1, 0, 1, 1, 4'd0, 7'h3C, 7'h64);  // 15
        add(8'h91, 1, 1, 0, 0, 4'd0, 7'h00, 7'h00);  // filtered instance
        add(8'h3C, 1, 1, 0, 0, 4'd0, 7'h00, 7'h00);
        add(8'h64, 1, 1, 0, 0, 4'd0, 7'h00, 7'h00);
        add(8'h92, 1, 1, 0, 0, 4'd0, 7'h00, 7'h00);
        add(8'h3C, 1, 1, 0, 0, 4'd0, 7'h00, 7'h00);  // 20
        add(8'h64, 1, 1, 1, 1, 4'd2, 7'h3C, 7'h64);
        add(8'hF0, 1, 0, 0, 0, 4'd0, 7'h00, 7'h00);  // SysEx clears status
        add(8'h3C, 1, 0, 0, 0, 4'd0, 7'h00, 7'h00);
        add(8'h64, 1, 0, 0, 0, 4'd0, 7'h00, 7'h00);
        add(8'hB0, 1, 0, 0, 0, 4'd0, 7'h00, 7'h00);  // 25 after mid-byte reset
        add(8'h07, 1, 0, 0, 0, 4'd0, 7'h00, 7'h00);
        add(8'h7F, 1, 0, 0, 0, 4'd0, 7'h00, 7'h00);
        add(8'h90, 1, 0, 0, 0, 4'd0, 7'h00, 7'h00);
        add(8'h3C, 1, 0, 0, 0, 4'd0, 7'h00, 7'h00);
        add(8'h64, 1, 0, 1, 1, 4'd0, 7'h3C, 7'h64);  // 30
        add(8'h90, 1, 0, 0, 0, 4'd0, 7'h00, 7'h00);
        add(8'h3C, 1, 0, 0, 0, 4'd0, 7'h00, 7'h00);
        add(8'h95, 1, 0, 0, 0, 4'd0, 7'h00, 7'h00);  // new status drops partial
        add(8'h40, 1, 0, 0, 0, 4'd0, 7'h00, 7'h00);
        add(8'h20, 1, 0, 1, 1, 4'd5, 7'h40, 7'h20);  // 35

        r  = 1'b1;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_u", {bv0, rxb0, fe0, nv0, on0, ch0, key0, vel0}, 32'd0);
        chk("reset_outputs_f", {bv1, rxb1, fe1, nv1, on1, ch1, key1, vel1}, 32'd0);
        r = 1'b0;
        repeat (3) drive_bit(1'b1);

        run_range(0, 11);

        fe_base = fe_cnt;
        bv_base = bv_cnt;
        send_vec(12);
        repeat (19) drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        chk("break_frame_err_pulses", fe_cnt - fe_base, 32'd1);
        chk("break_byte_valid_pulses", bv_cnt - bv_base, 32'd0);

        run_range(13, 24);

        // Reset sampled at E4 of a 0x90 byte (bits 0..3 are all low).
        drive_bit(1'b0);
        repeat (3) drive_bit(1'b0);
        r = 1'b1;
        drive_bit(1'b0);
        chk("midbyte_reset_outputs", {bv0, rxb0, fe0, nv0, on0, ch0, key0, vel0}, 32'd0);
        r = 1'b0;
        fe_base = fe_cnt;
        bv_base = bv_cnt;
        repeat (3) drive_bit(1'b0);
        repeat (12) drive_bit(1'b1);
        chk("post_reset_byte_valid", bv_cnt - bv_base, 32'd0);
        chk("post_reset_frame_err", fe_cnt - fe_base, 32'd0);

        run_range(25, 35);

        chk("bv_fe_overlap", both_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/midi_msg_ctrl.md
# midi_msg_ctrl

Receive-side controller for the MIDI input path. It runs on the 31.25 kHz bit clock, taking one sample per bit of the synchronized MIDI line. It frames each serial byte (start, 8 data bits LSB first, stop) and parses bytes into Note On/Off events, handling running status and real-time bytes. It replaces the free-running shift/count/frame-tracking logic that feeds the LED display stage with a single sequenced controller.

## Interface
Parameters:
- CHAN_FILTER_EN, default 0: 1 = emit events only for channel CHANNEL; 0 = all channels.
- CHANNEL, default 4'h0: MIDI channel (0–15) accepted when the filter is enabled.

Ports:
- clk  in  1  bit clock, 31.25 kHz, one sample per MIDI bit; all logic on posedge.
- r  in  1  synchronous reset, active-high.
- rx  in  1  synchronized MIDI line (idle high).
- byte_valid  out  1  one-cycle pulse; rx_byte holds a correctly framed byte.
- rx_byte  out  8  last framed byte; holds between pulses.
- frame_err  out  1  one-cycle pulse; stop bit sampled low.
- note_valid  out  1  one-cycle pulse; note_* fields are valid.
- note_on  out  1  1 = Note On with velocity > 0; 0 = Note Off, or Note On with velocity 0.
- note_chan  out  4  channel of the event.
- note_key  out  7  key number.
- note_vel  out  7  velocity (raw value, also for Note Off).

## Operation
- Framer FSM: IDLE, DATA, STOP, BREAK.
  - IDLE: rx=0 sampled → DATA, bit_cnt=0.
  - DATA: shift rx into shreg[bit_cnt] (LSB first), bit_cnt++. After the 8th bit → STOP.
  - STOP, rx=1: rx_byte←shreg, byte_valid=1 next cycle, → IDLE.
  - STOP, rx=0: frame_err=1 next cycle, byte discarded, → BREAK.
  - BREAK: stay until rx=1 sampled → IDLE. A held-low line never produces a byte.
- Parser (acts on the cycle byte_valid is high):
  - 0xF8–0xFF (real-time): ignored. Running status and data index unchanged.
  - 0xF0–0xF7 (system common/SysEx): running status cleared; subsequent data bytes ignored.
  - 0x80–0xEF: run_stat←byte, idx←0.
  - Data byte (bit7=0) with run_stat=0x8n/0x9n:
    - idx=0: key←byte, idx←1.
    - idx=1: vel←byte, idx←0, event emitted (subject to the channel filter).
  - Data byte with any other run_stat, or none: ignored.
  - Running status: after an event, further data-byte pairs produce events with no new status byte.
- note_on = (type==0x9) && (vel!=0).
- A new status byte mid-message discards the partial message (idx←0).
- Reset: FSM→IDLE, bit_cnt=0, run_stat=none, idx=0. All outputs 0: byte_valid, rx_byte, frame_err, note_valid, note_on, note_chan, note_key, note_vel.

## Timing
- Edge E0 samples the start bit. E1–E8 sample data bits 0–7. E9 samples the stop bit.
- byte_valid/frame_err are high in the cycle after E9 (E9→E10). The earliest next start bit is sampled at E10, so back-to-back bytes are 10 cycles apart with no gap.
- note_valid is high in the cycle after the velocity byte's byte_valid: 2 cycles after that byte's stop sample. note_* fields hold until the next event.
- Reset asserted mid-byte aborts the byte: no byte_valid, no frame_err. The line must be sampled high before a new start bit is accepted; post-reset behaves as BREAK until rx=1.
- byte_valid and frame_err are never high in the same cycle.

## Test plan
- Bytes 0x90,0x3C,0x64 back-to-back → three byte_valid pulses, then one note_valid: note_on=1, chan=0, key=0x3C, vel=0x64, exactly 2 cycles after the third stop bit.
- Continue with 0x3C,0x00 (running status) → note_valid with note_on=0, key=0x3C, vel=0x00. Then 0x80,0x40,0x10 → note_on=0, key=0x40, vel=0x10.
- Stream 0x95,0x3C,0xF8,0x64 → byte_valid for 0xF8 but no disturbance; one event: chan=5, key=0x3C, vel=0x64.
- Byte 0x90 with stop bit 0 and line held low 20 cycles → one frame_err pulse, no byte_valid. After rx returns high, 0x90,0x3C,0x64 decodes normally.
- CHAN_FILTER_EN=1, CHANNEL=2: 0x91,0x3C,0x64 → no note_valid; 0x92,0x3C,0x64 → note_valid with chan=2.
- Assert r at E4 of a byte → all outputs 0 next cycle, no byte_valid. Then 0xB0,0x07,0x7F,0x90,0x3C,0x64 → only the Note On event is emitted.
